// File: rtl/clock_pkg.sv
// Shared definitions for the OCXO clock-discipline blocks.
//   dac_spi_state_t : state encoding of the tuning-DAC SPI write controller
//   DAC_WIDTH       : width of the OCXO tuning DAC word
package clock_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT,
      HOLD,
      GAP
   } dac_spi_state_t;

   localparam int DAC_WIDTH = 16;

endpackage

// File: rtl/dac_spi.sv
// SPI write controller for the OCXO tuning DAC (SPI mode 0, MSB first).
// Requests are coalesced through a one-deep shadow register, so only the
// newest word is ever sent. Transfers are blocked and aborted while the DAC
// is disabled or the OCXO supply is still in its power-up tristate window.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   dac_ena    controller enable from the IO block
//   dac_tri    OCXO power-up tristate from the IO block (1 = do not drive)
//   dac_val    requested tuning word
//   dac_val_wr one-cycle strobe capturing dac_val
//   dac_sclk   SPI clock, idles low
//   dac_mosi   SPI data, changes on sclk falling
//   dac_cs_n   chip select, active low
//   dac_oe_n   pad output enable for sclk/mosi/cs_n (1 = tristate)
//   busy       high from cs_n falling through the end of the inter-frame gap
//   done       one-cycle pulse as cs_n rises after a completed transfer
//   dac_cur    last word fully transferred
module dac_spi
   import clock_pkg::*;
#(
   parameter int DATA_WIDTH = DAC_WIDTH,
   parameter int SCLK_DIV   = 5,
   parameter int CS_SETUP   = 2,
   parameter int CS_HOLD    = 2,
   parameter int CS_GAP     = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  dac_ena,
   input  logic                  dac_tri,
   input  logic [DATA_WIDTH-1:0] dac_val,
   input  logic                  dac_val_wr,
   output logic                  dac_sclk,
   output logic                  dac_mosi,
   output logic                  dac_cs_n,
   output logic                  dac_oe_n,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] dac_cur
);

   localparam int CNT_W = 16;
   localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   // Terminal counts for the single shared cycle counter.
   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
   localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(SCLK_DIV - 1);
   localparam logic [CNT_W-1:0] BITC_LAST  = CNT_W'(2 * SCLK_DIV - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(CS_GAP - 1);
   localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_WIDTH - 1);

   dac_spi_state_t        state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [BIT_W-1:0]      bit_q, bit_d;
   logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
   logic [DATA_WIDTH-1:0] word_q, word_d;     // word of the frame in flight
   logic [DATA_WIDTH-1:0] shadow_q, shadow_d;
   logic                  pending_q, pending_d;
   logic                  sclk_q, sclk_d;
   logic                  mosi_q, mosi_d;
   logic                  cs_n_q, cs_n_d;
   logic                  oe_n_q, oe_n_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic [DATA_WIDTH-1:0] cur_q, cur_d;

   logic                  go;
   logic [DATA_WIDTH-1:0] launch_word;

   assign go = dac_ena & ~dac_tri;
   // A strobe in the launch cycle bypasses the shadow so it is not lost.
   assign launch_word = dac_val_wr ? dac_val : shadow_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      shreg_d   = shreg_q;
      word_d    = word_q;
      shadow_d  = shadow_q;
      pending_d = pending_q;
      sclk_d    = sclk_q;
      mosi_d    = mosi_q;
      cs_n_d    = cs_n_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      cur_d     = cur_q;
      oe_n_d    = ~dac_ena | dac_tri;

      if (dac_val_wr) begin
         shadow_d  = dac_val;
         pending_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (go && (pending_q || dac_val_wr)) begin
               state_d   = SETUP;
               cnt_d     = '0;
               bit_d     = '0;
               shreg_d   = launch_word;
               word_d    = launch_word;
               mosi_d    = launch_word[DATA_WIDTH-1];
               cs_n_d    = 1'b0;
               busy_d    = 1'b1;
               pending_d = 1'b0;
            end
         end
         SETUP: begin
            if (cnt_q == SETUP_LAST) begin
               state_d = SHIFT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         SHIFT: begin
            // Each bit: SCLK_DIV cycles low then SCLK_DIV cycles high.
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == HALF_LAST) begin
               sclk_d = 1'b1;
            end
            if (cnt_q == BITC_LAST) begin
               cnt_d  = '0;
               sclk_d = 1'b0;
               if (bit_q == BIT_LAST) begin
                  state_d = HOLD;
               end else begin
                  bit_d   = bit_q + 1'b1;
                  shreg_d = shreg_q << 1;
                  mosi_d  = shreg_d[DATA_WIDTH-1];
               end
            end
         end
         HOLD: begin
            if (cnt_q == HOLD_LAST) begin
               state_d = GAP;
               cnt_d   = '0;
               cs_n_d  = 1'b1;
               mosi_d  = 1'b0;
               done_d  = 1'b1;
               cur_d   = word_q;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         GAP: begin
            if (cnt_q == GAP_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
               busy_d  = 1'b0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Losing go aborts whatever is in progress. An interrupted frame is
      // re-queued unless something newer is already waiting; a frame that
      // already completed (GAP) is not resent.
      if (state_q != IDLE && !go) begin
         state_d = IDLE;
         cnt_d   = '0;
         cs_n_d  = 1'b1;
         sclk_d  = 1'b0;
         mosi_d  = 1'b0;
         busy_d  = 1'b0;
         done_d  = 1'b0;
         cur_d   = cur_q;
         if (state_q != GAP && !pending_q && !dac_val_wr) begin
            shadow_d  = word_q;
            pending_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         bit_q     <= '0;
         shreg_q   <= '0;
         word_q    <= '0;
         shadow_q  <= '0;
         pending_q <= 1'b0;
         sclk_q    <= 1'b0;
         mosi_q    <= 1'b0;
         cs_n_q    <= 1'b1;
         oe_n_q    <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         cur_q     <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         shreg_q   <= shreg_d;
         word_q    <= word_d;
         shadow_q  <= shadow_d;
         pending_q <= pending_d;
         sclk_q    <= sclk_d;
         mosi_q    <= mosi_d;
         cs_n_q    <= cs_n_d;
         oe_n_q    <= oe_n_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         cur_q     <= cur_d;
      end
   end

   assign dac_sclk = sclk_q;
   assign dac_mosi = mosi_q;
   assign dac_cs_n = cs_n_q;
   assign dac_oe_n = oe_n_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign dac_cur  = cur_q;

endmodule

// File: tb/tb_dac_spi.sv
// Directed self-checking bench for dac_spi. A negedge monitor decodes the
// SPI bus into frames (bits sampled on sclk rising, cs_n timing) and the
// stimulus compares those against hand-computed values.
module tb_dac_spi;

   logic        clk;
   logic        rst;
   logic        dac_ena;
   logic        dac_tri;
   logic [15:0] dac_val;
   logic        dac_val_wr;
   logic        dac_sclk;
   logic        dac_mosi;
   logic        dac_cs_n;
   logic        dac_oe_n;
   logic        busy;
   logic        done;
   logic [15:0] dac_cur;

   int checks = 0;
   int errors = 0;

   dac_spi dut (
      .clk        (clk),
      .rst        (rst),
      .dac_ena    (dac_ena),
      .dac_tri    (dac_tri),
      .dac_val    (dac_val),
      .dac_val_wr (dac_val_wr),
      .dac_sclk   (dac_sclk),
      .dac_mosi   (dac_mosi),
      .dac_cs_n   (dac_cs_n),
      .dac_oe_n   (dac_oe_n),
      .busy       (busy),
      .done       (done),
      .dac_cur    (dac_cur)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- bus monitor (sampled on negedge) ----------------
   int          cyc = 0;
   logic        prev_sclk = 1'b0;
   logic        prev_cs = 1'b1;
   int          fall_cycle = 0;
   int          rise_cycle = 0;
   int          fall_cnt = 0;
   int          frame_cnt = 0;
   int          done_cnt = 0;
   int          nrise = 0;
   logic [15:0] rx = '0;
   logic [15:0] last_rx = '0;
   int          last_nrise = 0;
   int          last_len = 0;
   int          last_f2f = 0;
   int          last_gap = 0;
   logic        done_at_rise = 1'b0;

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (done === 1'b1) done_cnt = done_cnt + 1;
      if (prev_cs === 1'b1 && dac_cs_n === 1'b0) begin
         last_f2f   = cyc - fall_cycle;
         last_gap   = cyc - rise_cycle;
         fall_cycle = cyc;
         fall_cnt   = fall_cnt + 1;
         nrise      = 0;
         rx         = '0;
      end
      if (dac_cs_n === 1'b0 && prev_sclk === 1'b0 && dac_sclk === 1'b1) begin
         rx    = {rx[14:0], dac_mosi};
         nrise = nrise + 1;
      end
      if (prev_cs === 1'b0 && dac_cs_n === 1'b1) begin
         last_rx      = rx;
         last_nrise   = nrise;
         last_len     = cyc - fall_cycle;
         rise_cycle   = cyc;
         done_at_rise = done;
         frame_cnt    = frame_cnt + 1;
      end
      prev_cs   = dac_cs_n;
      prev_sclk = dac_sclk;
   end

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         errors = errors + 1;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end else begin
         $display("ok   %s = %h", tag, got);
      end
   endtask

   // Step past the next negedge (monitor has updated, outputs stable).
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Strobe a word; returns the cycle number in which the strobe was driven.
   task automatic write_word(input logic [15:0] v, output int c);
      tick();
      dac_val    = v;
      dac_val_wr = 1'b1;
      c          = cyc;
      tick();
      dac_val_wr = 1'b0;
   endtask

   task automatic wait_frame(input string tag, input int bound);
      int start;
      start = frame_cnt;
      for (int i = 0; i < bound && frame_cnt == start; i++) tick();
      check(tag, 32'(frame_cnt - start), 32'd1);
   endtask

   task automatic wait_rises(input string tag, input int n, input int bound);
      for (int i = 0; i < bound && !(dac_cs_n == 1'b0 && nrise >= n); i++) tick();
      check(tag, 32'(nrise), 32'(n));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int c;
      int f0;
      int d0;
      rst        = 1'b1;
      dac_ena    = 1'b0;
      dac_tri    = 1'b0;
      dac_val    = '0;
      dac_val_wr = 1'b0;
      ticks(3);

      // Reset state
      check("rst_cs_n", 32'(dac_cs_n), 32'd1);
      check("rst_sclk", 32'(dac_sclk), 32'd0);
      check("rst_mosi", 32'(dac_mosi), 32'd0);
      check("rst_oe_n", 32'(dac_oe_n), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_cur", 32'(dac_cur), 32'd0);
      rst     = 1'b0;
      dac_ena = 1'b1;
      ticks(2);
      check("oe_n_enabled", 32'(dac_oe_n), 32'd0);
      check("no_spurious_frame", 32'(fall_cnt), 32'd0);

      // 1: basic frame 0xA5C3
      d0 = done_cnt;
      write_word(16'hA5C3, c);
      check("t1_latency", 32'(fall_cycle - c), 32'd1);
      check("t1_busy", 32'(busy), 32'd1);
      wait_frame("t1_frame", 400);
      check("t1_cs_low_len", 32'(last_len), 32'd164);
      check("t1_rises", 32'(last_nrise), 32'd16);
      check("t1_bits", 32'(last_rx), 32'h0000A5C3);
      check("t1_done_at_rise", 32'(done_at_rise), 32'd1);
      check("t1_cur", 32'(dac_cur), 32'h0000A5C3);
      ticks(6);
      check("t1_done_once", 32'(done_cnt - d0), 32'd1);
      check("t1_busy_off", 32'(busy), 32'd0);

      // 2: tristate window blocks transfer until release
      dac_tri = 1'b1;
      ticks(2);
      check("t2_oe_n_tri", 32'(dac_oe_n), 32'd1);
      f0 = fall_cnt;
      write_word(16'h1234, c);
      ticks(500);
      check("t2_no_cs_activity", 32'(fall_cnt - f0), 32'd0);
      check("t2_oe_n_still_tri", 32'(dac_oe_n), 32'd1);
      dac_tri = 1'b0;
      c = cyc;
      tick();
      check("t2_start_after_release", 32'(fall_cycle - c), 32'd1);
      check("t2_oe_n_released", 32'(dac_oe_n), 32'd0);
      wait_frame("t2_frame", 400);
      check("t2_bits", 32'(last_rx), 32'h00001234);

      // 3: coalescing during SHIFT
      ticks(8);
      f0 = fall_cnt;
      write_word(16'h0001, c);
      wait_rises("t3_mid_shift", 4, 200);
      write_word(16'h8000, c);
      write_word(16'h7FFF, c);
      wait_frame("t3_frame_a", 400);
      check("t3_bits_a", 32'(last_rx), 32'h00000001);
      wait_frame("t3_frame_b", 400);
      check("t3_bits_b", 32'(last_rx), 32'h00007FFF);
      ticks(400);
      check("t3_frame_count", 32'(fall_cnt - f0), 32'd2);

      // 4: abort after bit 8 and resend
      d0 = done_cnt;
      write_word(16'hFFFF, c);
      wait_rises("t4_bit8", 8, 200);
      dac_ena = 1'b0;
      tick();
      check("t4_abort_cs_n", 32'(dac_cs_n), 32'd1);
      check("t4_abort_sclk", 32'(dac_sclk), 32'd0);
      check("t4_abort_busy", 32'(busy), 32'd0);
      ticks(3);
      check("t4_no_done", 32'(done_cnt - d0), 32'd0);
      check("t4_cur_kept", 32'(dac_cur), 32'h00007FFF);
      dac_ena = 1'b1;
      wait_frame("t4_resend", 400);
      check("t4_resend_bits", 32'(last_rx), 32'h0000FFFF);
      check("t4_resend_rises", 32'(last_nrise), 32'd16);
      check("t4_cur", 32'(dac_cur), 32'h0000FFFF);

      // 5: reset during SHIFT
      ticks(8);
      write_word(16'h1357, c);
      wait_rises("t5_mid_shift", 3, 200);
      rst = 1'b1;
      tick();
      check("t5_cs_n", 32'(dac_cs_n), 32'd1);
      check("t5_sclk", 32'(dac_sclk), 32'd0);
      check("t5_busy", 32'(busy), 32'd0);
      check("t5_cur", 32'(dac_cur), 32'd0);
      rst = 1'b0;
      f0 = fall_cnt;
      ticks(400);
      check("t5_no_restart", 32'(fall_cnt - f0), 32'd0);

      // 6: back-to-back requests
      write_word(16'h0100, c);
      wait_frame("t6_frame_a", 400);
      check("t6_bits_a", 32'(last_rx), 32'h00000100);
      write_word(16'h0200, c);
      wait_frame("t6_frame_b", 400);
      check("t6_bits_b", 32'(last_rx), 32'h00000200);
      check("t6_gap_ge_4", 32'(last_gap >= 4), 32'd1);
      check("t6_fall_to_fall", 32'(last_f2f), 32'd169);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #2000000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/dac_spi.md
Name: dac_spi

Overview:
- SPI write controller for the OCXO tuning DAC. Sits directly downstream of the GPIO/IO block and consumes its clk-domain dac_ena and dac_tri.
- Accepts 16-bit tuning words from the frequency-discipline logic and serialises them to the DAC.
- Blocks all transfers while the OCXO supply is off or still inside its turn-on tristate window.
- Coalesces requests: only the newest word is ever sent.

Parameters:
- DATA_WIDTH, 16: DAC word width; MSB is shifted first.
- SCLK_DIV, 5: sclk half-period, in clk cycles. Minimum 1.
- CS_SETUP, 2: clk cycles from cs_n falling to the first sclk rising edge (sclk stays low).
- CS_HOLD, 2: clk cycles from the last sclk falling edge to cs_n rising.
- CS_GAP, 4: minimum clk cycles cs_n stays high between transfers.

Ports:
- clk, in, 1: system clock (same domain as the IO block's clk-side outputs).
- rst, in, 1: synchronous, active-high reset.
- dac_ena, in, 1: DAC controller enable, from the IO block.
- dac_tri, in, 1: OCXO power-up tristate, from the IO block. 1 = DAC pins must not be driven.
- dac_val, in, DATA_WIDTH: requested tuning word.
- dac_val_wr, in, 1: one-cycle strobe that captures dac_val.
- dac_sclk, out, 1: SPI clock. Idles low (mode 0).
- dac_mosi, out, 1: SPI data. Changes on sclk falling; the DAC samples on sclk rising.
- dac_cs_n, out, 1: chip select, active low.
- dac_oe_n, out, 1: pad output-enable for sclk/mosi/cs_n. 1 = tristate.
- busy, out, 1: high from cs_n falling through the end of the CS_GAP period.
- done, out, 1: one-cycle pulse in the cycle cs_n rises after a completed transfer.
- dac_cur, out, DATA_WIDTH: last word fully transferred.

Behaviour:
- Reset values: sclk=0, mosi=0, cs_n=1, oe_n=1, busy=0, done=0, dac_cur=0, pending=0, shadow=0, state=IDLE.
- Capture: dac_val_wr loads shadow and sets pending, in every state.
  - A new strobe overwrites an unsent shadow; only the latest value is sent.
  - A write arriving during SHIFT does not alter the current frame.
- Gating: go = dac_ena & ~dac_tri.
  - oe_n = ~dac_ena | dac_tri, registered, so it lags the inputs by 1 cycle.
- IDLE:
  - If go & pending, next cycle: cs_n=0, load the shift register from shadow, clear pending, enter SETUP.
  - Latency: strobe at cycle N (IDLE, go=1) gives cs_n low at N+1.
  - If a strobe and a launch occur in the same cycle, the launch uses the incoming dac_val.
- SETUP: hold CS_SETUP cycles with mosi = MSB, then enter SHIFT.
- SHIFT: per bit, sclk low for SCLK_DIV cycles, then high for SCLK_DIV cycles.
  - mosi updates when sclk goes low, except for the first bit, which was presented in SETUP.
  - Exactly DATA_WIDTH rising edges.
- HOLD: sclk=0 for CS_HOLD cycles. Then cs_n=1, done=1 for 1 cycle, dac_cur=sent word, enter GAP.
- GAP: CS_GAP cycles, then enter IDLE and drop busy.
- cs_n low time: CS_SETUP + 2*SCLK_DIV*DATA_WIDTH + CS_HOLD cycles (164 with defaults).
- Request-to-request period: that value plus CS_GAP, plus 1 launch cycle (169 with defaults).
- Abort: go falling in any non-IDLE state.
  - Next cycle: cs_n=1, sclk=0, mosi=0, busy=0, state=IDLE; no done pulse; dac_cur unchanged.
  - pending is set again with the aborted word, unless a newer shadow write is already pending.
- Enable rise: if pending=0 when go rises, no transfer starts. Software must rewrite the word after power-up.
- Reset mid-transfer: all outputs return to reset values in the next cycle. pending and shadow are cleared.
- dac_val_wr with dac_ena=0: the value is still captured and is sent once go=1.

Decomposition:
- Shared package clock_pkg adds:
  - typedef dac_spi_state_t {IDLE, SETUP, SHIFT, HOLD, GAP}
  - localparam DAC_WIDTH=16
- Single module, no sub-modules.
- The bit/half-period counter sits inline. A generic clock-divider sub-module is not justified.

Test Plan:
- go=1, write 0xA5C3 → cs_n low 164 cycles; 16 sclk rising edges; sampled mosi bits = 1010_0101_1100_0011; done pulses once; dac_cur=0xA5C3.
- dac_tri=1, dac_ena=1, write 0x1234; release dac_tri 500 cycles later → no cs_n activity and oe_n=1 while tri; transfer of 0x1234 starts 1 cycle after release.
- During SHIFT of 0x0001, write 0x8000 then 0x7FFF → current frame sends 0x0001 unchanged; exactly one following frame sends 0x7FFF; 0x8000 never appears.
- Drop dac_ena after bit 8 of 0xFFFF → cs_n=1 next cycle, no done, dac_cur stays at its old value; re-raise dac_ena → full 0xFFFF frame resent.
- Assert rst during SHIFT → cs_n=1, sclk=0, busy=0, dac_cur=0 next cycle; no transfer afterwards without a new write.
- Back-to-back writes 0x0100, then 0x0200 issued after done → cs_n high ≥4 cycles between frames; consecutive cs_n falling edges ≥169 cycles apart.
